// File: rtl/pll_reset_ce.sv
// Purpose: qualify PLL lock and external reset, release a held-off system reset, and generate two fractional clock enables.
// Latency: sys_reset_n rises 3+HOLD_CYCLES edges after lock is first sampled clean, and falls 3 edges after lock loss or ext_reset.
// Backpressure: none; free-running outputs, enables are gated off whenever the block is not in RUN.
module pll_reset_ce #(
    parameter int HOLD_CYCLES = 1024,
    parameter int NUM0        = 8,
    parameter int DEN0        = 125,
    parameter int NUM1        = 16,
    parameter int DEN1        = 125
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic ext_reset,
    output logic sys_reset_n,
    output logic ce0,
    output logic ce1,
    output logic ready
);

    localparam int CW  = $clog2(HOLD_CYCLES) + 1;
    localparam int AW0 = $clog2(DEN0) + 1;
    localparam int AW1 = $clog2(DEN1) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [AW0:0]  NUM0_V    = (AW0 + 1)'(NUM0);
    localparam logic [AW0:0]  DEN0_V    = (AW0 + 1)'(DEN0);
    localparam logic [AW1:0]  NUM1_V    = (AW1 + 1)'(NUM1);
    localparam logic [AW1:0]  DEN1_V    = (AW1 + 1)'(DEN1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Synchroniser stages for the two asynchronous inputs
    logic lock_s1_q, lock_s1_d, lock_s_q, lock_s_d;
    logic ext_s1_q, ext_s1_d, ext_s_q, ext_s_d;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic [AW0-1:0]  acc0_q, acc0_d;
    logic [AW1-1:0]  acc1_q, acc1_d;
    logic            ce0_q, ce0_d;
    logic            ce1_q, ce1_d;

    logic            clean;
    logic            acc_en;
    logic [AW0:0]    sum0;
    logic [AW1:0]    sum1;
    logic            carry0, carry1;

    // Two-flop synchroniser next values; nothing else looks at the raw inputs
    always_comb begin
        lock_s1_d = pll_locked;
        lock_s_d  = lock_s1_q;
        ext_s1_d  = ext_reset;
        ext_s_d   = ext_s1_q;
    end

    // Synchroniser flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_s1_q <= 1'b0;
            lock_s_q  <= 1'b0;
            ext_s1_q  <= 1'b0;
            ext_s_q   <= 1'b0;
        end else begin
            lock_s1_q <= lock_s1_d;
            lock_s_q  <= lock_s_d;
            ext_s1_q  <= ext_s1_d;
            ext_s_q   <= ext_s_d;
        end
    end

    // State register and hold counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: any dirty sample (lock lost or reset requested) aborts HOLD/RUN before counting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean   = lock_s_q & ~ext_s_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (clean) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!clean) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!clean) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: the run flag is a dedicated flop so reset release is glitch-free
    always_comb begin
        run_d = (state_q == RUN);
    end

    // Phase accumulators: advance only while staying in RUN, so re-entry always starts from phase 0
    always_comb begin
        acc_en = (state_q == RUN) && (state_d == RUN);
        sum0   = {1'b0, acc0_q} + NUM0_V;
        sum1   = {1'b0, acc1_q} + NUM1_V;
        carry0 = (sum0 >= DEN0_V);
        carry1 = (sum1 >= DEN1_V);
        acc0_d = '0;
        acc1_d = '0;
        if (acc_en) begin
            acc0_d = AW0'(carry0 ? (sum0 - DEN0_V) : sum0);
            acc1_d = AW1'(carry1 ? (sum1 - DEN1_V) : sum1);
        end
        ce0_d = (state_q == RUN) && carry0;
        ce1_d = (state_q == RUN) && carry1;
    end

    // Run flag, accumulators and registered enables
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q  <= 1'b0;
            acc0_q <= '0;
            acc1_q <= '0;
            ce0_q  <= 1'b0;
            ce1_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            acc0_q <= acc0_d;
            acc1_q <= acc1_d;
            ce0_q  <= ce0_d;
            ce1_q  <= ce1_d;
        end
    end

    assign sys_reset_n = run_q;
    assign ready       = run_q;
    assign ce0         = ce0_q;
    assign ce1         = ce1_q;

endmodule

// File: tb/tb_pll_reset_ce.sv
// Purpose: self-checking bench for pll_reset_ce with two parameterisations sharing one stimulus.
// Latency: compares every cycle on the falling edge against a streak/rate model.
// Backpressure: not applicable.
module tb_pll_reset_ce;

    localparam int H = 16;

    logic clk;
    logic reset_n;
    logic pll_locked;
    logic ext_reset;

    logic sys_a, ce0_a, ce1_a, rdy_a;
    logic sys_b, ce0_b, ce1_b, rdy_b;

    int total;
    int bad;

    pll_reset_ce #(
        .HOLD_CYCLES(H), .NUM0(8), .DEN0(125), .NUM1(16), .DEN1(125)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .ext_reset(ext_reset),
        .sys_reset_n(sys_a), .ce0(ce0_a), .ce1(ce1_a), .ready(rdy_a)
    );

    pll_reset_ce #(
        .HOLD_CYCLES(H), .NUM0(8), .DEN0(125), .NUM1(5), .DEN1(5)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .ext_reset(ext_reset),
        .sys_reset_n(sys_b), .ce0(ce0_b), .ce1(ce1_b), .ready(rdy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Number of pulses in run cycle r is the step in floor(r*n/d)
    function automatic logic pulse(input int r, input int n, input int d);
        return ((r * n) / d) != (((r - 1) * n) / d);
    endfunction

    // Model: the output is up when the clean-input streak seen three edges ago
    // covers the full synchroniser + hold window; enables follow the ideal rate.
    int   h0, h1, h2, r;
    logic exp_run, exp_ce0, exp_ce1a, exp_ce1b;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h0       <= 0;
            h1       <= 0;
            h2       <= 0;
            r        <= 0;
            exp_run  <= 1'b0;
            exp_ce0  <= 1'b0;
            exp_ce1a <= 1'b0;
            exp_ce1b <= 1'b0;
        end else begin
            h0       <= (pll_locked && !ext_reset) ? h0 + 1 : 0;
            h1       <= h0;
            h2       <= h1;
            exp_run  <= (h2 >= H + 1);
            r        <= (h2 >= H + 1) ? r + 1 : 0;
            exp_ce0  <= (h2 >= H + 1) && pulse(r + 1, 8, 125);
            exp_ce1a <= (h2 >= H + 1) && pulse(r + 1, 16, 125);
            exp_ce1b <= (h2 >= H + 1) && pulse(r + 1, 5, 5);
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_sys_a", sys_a, 1'b0);
            chk("rst_rdy_a", rdy_a, 1'b0);
            chk("rst_ce0_a", ce0_a, 1'b0);
            chk("rst_ce1_b", ce1_b, 1'b0);
        end else begin
            chk("sys_a", sys_a, exp_run);
            chk("rdy_a", rdy_a, exp_run);
            chk("ce0_a", ce0_a, exp_ce0);
            chk("ce1_a", ce1_a, exp_ce1a);
            chk("sys_b", sys_b, exp_run);
            chk("rdy_b", rdy_b, exp_run);
            chk("ce0_b", ce0_b, exp_ce0);
            chk("ce1_b", ce1_b, exp_ce1b);
        end
    end

    // Drive a clean release starting at the next edge and check the release edge is 19
    task automatic release_check(input string nm);
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);
            if (k == 18) begin
                chk({nm, "_pre"}, sys_a, 1'b0);
                chk({nm, "_pre_ce0"}, ce0_a, 1'b0);
                chk({nm, "_pre_ce1b"}, ce1_b, 1'b0);
            end
            if (k == 19) begin
                chk({nm, "_edge19"}, sys_a, 1'b1);
                chk({nm, "_model19"}, exp_run, 1'b1);
            end
        end
    endtask

    initial begin
        int cnt0, cnt1, cnt1b, first, consec, highs;
        logic prev;
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        ext_reset  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_sys", sys_a, 1'b0);

        // Lock rises: release 19 edges later
        pll_locked = 1'b1;
        release_check("rel1");

        // 1250 RUN cycles: pulse counts, first pulse position, no back-to-back ce0
        cnt0 = 0; cnt1 = 0; cnt1b = 0; first = 0; consec = 0; prev = 1'b0;
        for (int i = 1; i <= 1250; i++) begin
            if (ce0_a) begin
                cnt0++;
                if (first == 0) first = i;
                if (prev) consec++;
            end
            prev = ce0_a;
            if (ce1_a) cnt1++;
            if (ce1_b) cnt1b++;
            @(negedge clk);
        end
        chk_int("ce0_count", cnt0, 80);
        chk_int("ce1_count", cnt1, 160);
        chk_int("ce0_first", first, 16);
        chk_int("ce0_consec", consec, 0);
        chk_int("ce1b_const", cnt1b, 1250);

        // Lock loss during HOLD aborts the hold; a full hold follows the re-raise
        pll_locked = 1'b0;
        repeat (10) @(negedge clk);
        chk("lost_sys", sys_a, 1'b0);
        pll_locked = 1'b1;
        for (int k = 0; k <= 11; k++) @(negedge clk);
        pll_locked = 1'b0;
        highs = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sys_a) highs++;
        end
        chk_int("hold_abort_highs", highs, 0);
        pll_locked = 1'b1;
        release_check("rel2");

        // One-cycle ext_reset in RUN
        repeat (5) @(negedge clk);
        ext_reset = 1'b1;
        @(negedge clk);
        ext_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ext_d2_sys", sys_a, 1'b1);
        @(negedge clk);
        chk("ext_d3_sys", sys_a, 1'b0);
        chk("ext_d3_ce0", ce0_a, 1'b0);
        chk("ext_d3_ce1b", ce1_b, 1'b0);
        for (int j = 4; j <= 20; j++) begin
            @(negedge clk);
            if (j == 19) chk("ext_rel_pre", sys_a, 1'b0);
            if (j == 20) chk("ext_rel", sys_a, 1'b1);
        end
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            if (ce0_a && first == 0) first = i;
            @(negedge clk);
        end
        chk_int("ext_ce0_first", first, 16);

        // Asynchronous reset mid-RUN, between edges
        chk("pre_async_ce1b", ce1_b, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_sys_a", sys_a, 1'b0);
        chk("async_rdy_a", rdy_a, 1'b0);
        chk("async_ce0_a", ce0_a, 1'b0);
        chk("async_ce1_a", ce1_a, 1'b0);
        chk("async_ce1_b", ce1_b, 1'b0);
        chk("async_sys_b", sys_b, 1'b0);
        chk_int("async_acc0", int'(dut_a.acc0_q), 0);
        chk_int("async_acc1", int'(dut_a.acc1_q), 0);
        chk_int("async_cnt", int'(dut_a.cnt_q), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        release_check("rel3");
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
